// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select codes, fetch FSM states and default widths shared by the fetch stage and decoder.
package pc_pkg;
    typedef enum logic [1:0] {PC_INC, PC_JMP, PC_BEQ, PC_WAIT} pc_ctrl_t;
    typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO} fsm_t;
    localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/go_sync.sv
// go_sync: multi-flop synchroniser bringing the asynchronous go push-button into the clock domain.
module go_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic rst,
    input  logic go,
    output logic go_s
);
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge clock) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], go};
    end
    assign go_s = sync[SYNC_STAGES-1];
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencer with increment, jump, relative branch and go-button wait.
module pc_fetch
    import pc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int RESET_ADDR  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              stall,
    input  pc_ctrl_t          pc_ctrl,
    input  logic [ADDR_W-1:0] target,
    input  logic              flag_z,
    input  logic              go,
    output logic [ADDR_W-1:0] addr,
    output logic              waiting
);
    fsm_t state, state_n;
    logic [ADDR_W-1:0] addr_n, seq, branch;
    logic go_s, go_d;

    go_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock(clock),
        .rst  (rst),
        .go   (go),
        .go_s (go_s)
    );

    // Retiming flop keeps sampling through stalls so a release seen while stalled acts immediately after.
    always_ff @(posedge clock) begin
        if (rst) go_d <= 1'b0;
        else     go_d <= go_s;
    end

    // Same-width add wraps modulo 2^ADDR_W, which equals adding the sign-extended offset.
    assign seq    = addr + 1'b1;
    assign branch = addr + target;

    always_comb begin
        state_n = state;
        addr_n  = addr;
        case (state)
            RUN: begin
                case (pc_ctrl)
                    PC_INC:  addr_n = seq;
                    PC_JMP:  addr_n = target;
                    PC_BEQ:  addr_n = flag_z ? branch : seq;
                    default: state_n = WAIT_HI;
                endcase
            end
            WAIT_HI: state_n = go_d ? WAIT_LO : WAIT_HI;
            WAIT_LO: begin
                state_n = go_d ? WAIT_LO : RUN;
                addr_n  = go_d ? addr : seq;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= RUN;
            addr    <= ADDR_W'(RESET_ADDR);
            waiting <= 1'b0;
        end else if (!stall) begin
            state   <= state_n;
            addr    <= addr_n;
            waiting <= state_n != RUN;
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed vectors with hand-computed expected PC and waiting values for pc_fetch.
module tb_pc_fetch;
    import pc_pkg::*;

    logic       clock = 1'b0;
    logic       rst, stall, flag_z, go, waiting;
    pc_ctrl_t   pc_ctrl;
    logic [4:0] target, addr;
    int vectors = 0, miscompares = 0;

    pc_fetch #(.ADDR_W(5), .RESET_ADDR(0), .SYNC_STAGES(2)) dut (
        .clock  (clock),
        .rst    (rst),
        .stall  (stall),
        .pc_ctrl(pc_ctrl),
        .target (target),
        .flag_z (flag_z),
        .go     (go),
        .addr   (addr),
        .waiting(waiting)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_pc(input string tag, input int a, input int w);
        check({tag, "_addr"}, int'(addr), a);
        check({tag, "_wait"}, int'(waiting), w);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flag_z = 1'b0; go = 1'b0;
        pc_ctrl = PC_INC; target = '0;
        tick(2);
        rst = 1'b0;
        expect_pc("reset", 0, 0);
        // INC across the 31 -> 0 wrap
        for (int i = 1; i <= 35; i++) begin
            tick();
            expect_pc("inc", i % 32, 0);
        end
        tick(4);
        expect_pc("at7", 7, 0);
        pc_ctrl = PC_JMP; target = 5'd20;
        tick();
        expect_pc("jmp20", 20, 0);
        pc_ctrl = PC_BEQ; target = 5'b11100; flag_z = 1'b1;
        tick();
        expect_pc("beq_taken_neg4", 16, 0);
        pc_ctrl = PC_JMP; target = 5'd20;
        tick();
        pc_ctrl = PC_BEQ; target = 5'b11100; flag_z = 1'b0;
        tick();
        expect_pc("beq_not_taken", 21, 0);
        target = 5'd0; flag_z = 1'b1;
        tick();
        expect_pc("beq_self_loop", 21, 0);
        target = 5'd15;
        tick();
        expect_pc("beq_plus15_wrap", 4, 0);
        // WAIT with a go pulse
        pc_ctrl = PC_JMP; target = 5'd3;
        tick();
        expect_pc("jmp3", 3, 0);
        pc_ctrl = PC_WAIT;
        tick();
        expect_pc("wait_enter", 3, 1);
        pc_ctrl = PC_JMP; target = 5'd9;
        tick(3);
        expect_pc("wait_ignore_ctrl", 3, 1);
        go = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_pc("go_high", 3, 1);
        end
        go = 1'b0; pc_ctrl = PC_INC;
        tick(3);
        expect_pc("release_plus3", 3, 1);
        tick();
        expect_pc("release_plus4", 4, 0);
        tick();
        expect_pc("after_wait_inc", 5, 0);
        // go already high on WAIT entry
        go = 1'b1; pc_ctrl = PC_WAIT;
        tick();
        expect_pc("wait_go_high", 5, 1);
        pc_ctrl = PC_INC;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i % 10 == 9) expect_pc("held_go_high", 5, 1);
        end
        go = 1'b0;
        tick(3);
        expect_pc("hi_release_plus3", 5, 1);
        tick();
        expect_pc("hi_release_plus4", 6, 0);
        // stall during INC
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_pc("stall_inc", 6, 0);
        end
        stall = 1'b0;
        tick();
        expect_pc("unstall_inc", 7, 0);
        // stall in WAIT_LO with go released during the stall
        pc_ctrl = PC_WAIT;
        tick();
        pc_ctrl = PC_INC; go = 1'b1;
        tick(5);
        expect_pc("wait_lo_7", 7, 1);
        stall = 1'b1; go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_pc("stall_wait_lo", 7, 1);
        end
        stall = 1'b0;
        tick();
        expect_pc("unstall_release", 8, 0);
        // reset while in WAIT_LO
        pc_ctrl = PC_JMP; target = 5'd12;
        tick();
        expect_pc("jmp12", 12, 0);
        pc_ctrl = PC_WAIT;
        tick();
        pc_ctrl = PC_INC; go = 1'b1;
        tick(5);
        expect_pc("wait_lo_12", 12, 1);
        rst = 1'b1;
        tick();
        expect_pc("reset_mid_wait", 0, 0);
        rst = 1'b0; go = 1'b0;
        tick();
        expect_pc("post_reset_inc1", 1, 0);
        tick();
        expect_pc("post_reset_inc2", 2, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
